// File: rtl/pipe_reg_chain_pkg.sv
// Shared constants and helpers for the elastic register pipeline.
// Default geometry and the width of the occupancy counter live here so that
// the chain and its users agree on them.
package pipe_reg_chain_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 2;

    // Bits needed to count 0..depth occupied stages
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One valid/data register pair of the elastic pipeline.
// The stage is ready when it is empty or when the stage after it is taking its
// word this cycle, so empty stages never block traffic. Data only moves when
// a real word arrives; the register keeps its previous contents under a bubble.
module pipe_reg_stage
    import pipe_reg_chain_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    input  logic             down_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic rdy;

    assign rdy = ~valid | down_ready;

    // Load from the previous stage when ready, otherwise stall; clear drops the word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (rdy) begin
            valid <= prev_valid;
            if (prev_valid) begin
                data <= prev_data;
            end
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic valid/ready register pipeline of DEPTH stages, WIDTH bits each.
// Bubbles collapse because every empty stage is ready; in_ready reaches back
// combinationally from out_ready through the whole chain.
// Optional feature: define PIPE_REG_CHAIN_FLUSH_EN to add the flush port,
// which empties every stage in one cycle and blocks both handshakes meanwhile.
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    input  logic                        out_ready,
    output logic [count_w(DEPTH)-1:0]   count
`ifdef PIPE_REG_CHAIN_FLUSH_EN
    ,
    input  logic                        flush
`endif
);

    localparam int CW = count_w(DEPTH);

    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat [DEPTH];
    logic [DEPTH-1:0] down_rdy;
    logic             clr;
    logic             in_xfer;
    logic             out_xfer;

`ifdef PIPE_REG_CHAIN_FLUSH_EN
    assign clr = flush;
`else
    assign clr = 1'b0;
`endif

    // Ready seen by each stage from its downstream neighbour, built from the output back
    always_comb begin
        down_rdy = '0;
        down_rdy[DEPTH-1] = out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            down_rdy[i] = ~vld[i+1] | down_rdy[i+1];
        end
    end

    assign in_ready  = (~vld[0] | down_rdy[0]) & ~clr;
    assign out_valid = vld[DEPTH-1] & ~clr;
    assign out_data  = dat[DEPTH-1];

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic             pv;
        logic [WIDTH-1:0] pd;

        if (g == 0) begin : g_first
            assign pv = in_valid;
            assign pd = in_data;
        end else begin : g_rest
            assign pv = vld[g-1];
            assign pd = dat[g-1];
        end

        pipe_reg_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr        (clr),
            .prev_valid (pv),
            .prev_data  (pd),
            .down_ready (down_rdy[g]),
            .valid      (vld[g]),
            .data       (dat[g])
        );
    end

    // Occupancy tracks the handshakes: +1 on accept, -1 on delivery, both cancel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (in_xfer && !out_xfer) begin
            count <= count + CW'(1);
        end else if (out_xfer && !in_xfer) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain (WIDTH=16, DEPTH=3). Reference model: an ordered
// list of words, each tagged with how far down the chain it has travelled.
module tb_pipe_reg_chain;

    localparam int WIDTH = 16;
    localparam int DEPTH = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [1:0]       count;
    logic             flush_r;

    int total = 0;
    int bad   = 0;

    int               pos_q[$];
    logic [WIDTH-1:0] dat_q[$];

    pipe_reg_chain #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
`ifdef PIPE_REG_CHAIN_FLUSH_EN
        ,
        .flush     (flush_r)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slot left free for the youngest word after everyone moves as far as allowed
    function automatic int lim_after(input bit ordy);
        int lim = DEPTH - 1;
        for (int i = 0; i < pos_q.size(); i++) begin
            if (i == 0 && pos_q[0] == DEPTH - 1 && ordy) begin
                lim = DEPTH - 1;
            end else begin
                int np = (pos_q[i] + 1 < lim) ? pos_q[i] + 1 : lim;
                lim = np - 1;
            end
        end
        return lim;
    endfunction

    task automatic advance(input bit iv, input logic [WIDTH-1:0] d, input bit ordy, input bit fl);
        bit acc;
        bit leave;
        int lim;
        if (fl) begin
            pos_q.delete();
            dat_q.delete();
            return;
        end
        acc   = iv && (lim_after(ordy) >= 0);
        leave = 1'b0;
        lim   = DEPTH - 1;
        for (int i = 0; i < pos_q.size(); i++) begin
            if (i == 0 && pos_q[0] == DEPTH - 1 && ordy) begin
                leave = 1'b1;
            end else begin
                int np = (pos_q[i] + 1 < lim) ? pos_q[i] + 1 : lim;
                pos_q[i] = np;
                lim = np - 1;
            end
        end
        if (leave) begin
            void'(pos_q.pop_front());
            void'(dat_q.pop_front());
        end
        if (acc) begin
            pos_q.push_back(0);
            dat_q.push_back(d);
        end
    endtask

    // One clock: drive at the falling edge, check before the rising edge, then step the model
    task automatic cyc(input bit iv, input logic [WIDTH-1:0] d, input bit ordy, input bit fl);
        bit exp_irdy;
        bit exp_ov;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush_r   = fl;
        #1;
        exp_irdy = !fl && (lim_after(ordy) >= 0);
        exp_ov   = !fl && pos_q.size() > 0 && pos_q[0] == DEPTH - 1;
        chk("in_ready", 32'(in_ready), 32'(exp_irdy));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("count", 32'(count), 32'(pos_q.size()));
        if (exp_ov) chk("out_data", 32'(out_data), 32'(dat_q[0]));
        @(posedge clk);
        advance(iv, d, ordy, fl);
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"}, 32'(out_data), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush_r   = 1'b0;
        #1;
        chk_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming: 16 back-to-back words, free-running output
        for (int i = 1; i <= 16; i++) cyc(1'b1, 16'(i), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);

        // Fill and stall: fourth word refused, head word held steady
        for (int i = 1; i <= 4; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'h0004, 1'b0, 1'b0);
        chk("full_count", 32'(count), 32'd3);
        chk("full_head", 32'(out_data), 32'h0001);

        // Simultaneous in/out while full
        for (int i = 4; i <= 9; i++) cyc(1'b1, 16'(i), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);

        // Bubble collapse: a lone word drifts to the output under stall
        cyc(1'b1, 16'h00aa, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'h00b0 + 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);

`ifdef PIPE_REG_CHAIN_FLUSH_EN
        // Flush with two words held and a word offered
        cyc(1'b1, 16'h00c1, 1'b0, 1'b0);
        cyc(1'b1, 16'h00c2, 1'b0, 1'b0);
        cyc(1'b1, 16'h00c3, 1'b0, 1'b1);
        for (int i = 4; i <= 7; i++) cyc(1'b1, 16'h00c0 + 16'(i), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit fl;
            fl = 1'b0;
`ifdef PIPE_REG_CHAIN_FLUSH_EN
            fl = ($urandom_range(0, 24) == 0);
`endif
            cyc($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) != 0, fl);
        end

        // Asynchronous reset in the middle of a stream
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'h0d00 + 16'(i), 1'b0, 1'b0);
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("async_reset");
        pos_q.delete();
        dat_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) cyc(1'b1, 16'h0e00 + 16'(i), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_reg_chain.md
# pipe_reg_chain

Parametrised elastic register pipeline: a chain of DEPTH valid/ready register stages, each WIDTH bits wide. It generalises the plain register bank with per-stage valid tracking, backpressure with bubble collapsing, and an occupancy count. Insert it on any long datapath between RTHS processing blocks where timing closure needs extra registers without losing throughput or dropping data under stall.

## Interface
Parameters:
- WIDTH, 16, data bits per stage (>=1)
- DEPTH, 2, number of register stages (>=1)

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream has a word on in_data
- in_data  in  WIDTH  upstream word
- in_ready  out  1  chain accepts a word this cycle
- out_valid  out  1  last stage holds a word
- out_data  out  WIDTH  last-stage word
- out_ready  in  1  downstream accepts out_data this cycle
- count  out  $clog2(DEPTH+1)  number of occupied stages
- flush  in  1  clear all stages (present only with PIPE_REG_CHAIN_FLUSH_EN)

## Operation
- Per stage i (0 = input side, DEPTH-1 = output side): valid_q[i], data_q[i].
- Stage ready: rdy[DEPTH-1] = ~valid_q[DEPTH-1] | out_ready; rdy[i] = ~valid_q[i] | rdy[i+1]. Combinational chain; empty stages (bubbles) are always ready, so bubbles collapse.
- in_ready = rdy[0]; out_valid = valid_q[DEPTH-1]; out_data = data_q[DEPTH-1].
- Stage i loads when rdy[i]=1: valid_q[i] <= valid of the stage before it (in_valid for i=0); data_q[i] <= data of the stage before it only if that valid=1, otherwise data_q[i] holds.
- Stage with rdy[i]=0 holds valid and data unchanged (stall).
- Transfer on a port occurs only when valid and ready are both 1 in the same cycle; words never duplicated, dropped or reordered.
- count = population count of valid_q, registered alongside valid_q (updated +1 on input transfer, -1 on output transfer, unchanged when both or neither). Never exceeds DEPTH.
- in_valid/in_data values while in_ready=0 are ignored; upstream must hold them (standard valid/ready rule, not checked).

## Timing
- Reset (rst_n=0, asynchronous): all valid_q=0, all data_q=0, count=0 -> in_ready=1, out_valid=0, out_data=0. Reset asserted mid-transfer discards all words; release is synchronous to clk by the system.
- Latency: a word accepted at edge N appears on out_data after edge N+DEPTH-1 when no stall (visible DEPTH cycles after the accepting cycle's in_valid).
- Throughput: one word per cycle sustained when out_ready=1.
- Full (count=DEPTH) and out_ready=0: in_ready=0. Full with out_ready=1: in_ready=1 same cycle (simultaneous in/out, count stays DEPTH).
- Empty (count=0): out_valid=0; in_ready=1 regardless of out_ready.
- in_ready has a combinational path from out_ready (length DEPTH); intended.

## Configuration
- PIPE_REG_CHAIN_FLUSH_EN defined: flush port exists. flush=1 forces in_ready=0 and out_valid=0 that cycle (no transfers); at the edge all valid_q<=0, count<=0, data_q unchanged. flush has priority over all handshakes.
- Not defined: no flush port; stages cleared only by rst_n.

## Structure
- Shared package pipe_reg_chain_pkg: default WIDTH/DEPTH constants and the count-width function (clog2 of DEPTH+1).
- One sub-module pipe_reg_stage (one valid/data register pair with ready computation), instantiated DEPTH times by a generate loop; top level holds the ready chain, count and flush.

## Test plan
- Reset: WIDTH=16, DEPTH=3, rst_n low mid-stream -> out_valid=0, out_data=16'h0000, count=0, in_ready=1 immediately (asynchronous).
- Streaming: out_ready=1, push 16'h0001..16'h0010 back-to-back -> each appears on out_data exactly 3 cycles after acceptance, in order, in_ready constant 1.
- Fill/stall: out_ready=0, push 4 words -> first 3 accepted, count=3, in_ready=0 on 4th; out_data holds 16'h0001 stable while stalled.
- Bubble collapse: one word in stage 0, out_ready=0 for 5 cycles -> word advances to stage 2, count=1, in_ready stays 1 until 3 words held.
- Simultaneous in/out when full: count=3, in_valid=1, out_ready=1 -> both transfer, count remains 3, order preserved.
- Flush (macro defined): count=2, flush=1 with in_valid=1 -> in_ready=0, out_valid=0 that cycle; next cycle count=0, out_valid=0, no word lost from after-flush traffic.
